// File: rtl/decoder3x8_hold.sv
// decoder3x8_hold: registered 3-to-8 decoder with valid/ready accept and programmable hold time.
// Optional even-parity check on the incoming code is enabled by defining DECODER3X8_PARITY_EN.
module decoder3x8_hold #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic valid,
    input  logic x0,
    input  logic x1,
    input  logic x2,
`ifdef DECODER3X8_PARITY_EN
    input  logic p,
    output logic err,
`endif
    output logic ready,
    output logic y0,
    output logic y1,
    output logic y2,
    output logic y3,
    output logic y4,
    output logic y5,
    output logic y6,
    output logic y7,
    output logic done
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    code_q, code_d;
    logic [7:0]    y_q, y_d;
    logic          done_q, done_d;
    logic [2:0]    code_in;
    logic          last, accept, take;

    assign code_in = {x2, x1, x0};
    assign last    = (state_q == HOLD) && (cnt_q == '0);
    assign ready   = en & ((state_q == IDLE) | last);
    assign accept  = valid & ready;

`ifdef DECODER3X8_PARITY_EN
    logic err_q, err_d, par_bad;
    assign par_bad = ^{code_in, p};
    assign take    = accept & ~par_bad;
    assign err_d   = accept & par_bad;
    assign err     = err_q;
    // A bad-parity code is dropped; report it one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
`else
    assign take = accept;
`endif

    // Next state: abort on en low, (re)load on accept, otherwise count the hold down.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (take) begin
            state_d = HOLD;
            cnt_d   = CW'(HOLD_CYCLES - 1);
            code_d  = code_in;
        end else if (state_q == HOLD) begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - CW'(1);
        end
        y_d    = (state_d == HOLD) ? 8'(1) << code_d : '0;
        done_d = (state_d == HOLD) && (cnt_d == '0);
    end

    // State, counter, latched code and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    assign {y7, y6, y5, y4, y3, y2, y1, y0} = y_q;
    assign done = done_q;
endmodule

// File: tb/tb_decoder3x8_hold.sv
// tb_decoder3x8_hold: scoreboard bench for decoder3x8_hold against a line/remaining-cycles model.
module tb_decoder3x8_hold;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst, en, valid, x0, x1, x2, ready, done;
    logic y0, y1, y2, y3, y4, y5, y6, y7;
`ifdef DECODER3X8_PARITY_EN
    logic p, err;
`endif

    always #5 clk = ~clk;

    decoder3x8_hold #(.HOLD_CYCLES(H)) dut (
        .clk(clk), .rst(rst), .en(en), .valid(valid),
        .x0(x0), .x1(x1), .x2(x2),
`ifdef DECODER3X8_PARITY_EN
        .p(p), .err(err),
`endif
        .ready(ready),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
        .done(done)
    );

    typedef struct {
        logic       r;
        logic [7:0] y;
        logic       d;
        logic       e;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    // Model: which line is lit (-1 none) and how many lit cycles remain including this one.
    int   line = -1;
    int   rem = 0;
    logic err_pend = 1'b0;

    function automatic logic [7:0] yv();
        return {y7, y6, y5, y4, y3, y2, y1, y0};
    endfunction

    task automatic check(input string n, input logic [7:0] a, input logic [7:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %b, required %b", n, a, e);
        end
    endtask

    // Drive one cycle, push the expected outputs for it, then advance the model across the edge.
    task automatic cycle(input logic e, input logic v, input logic [2:0] c, input logic bad, output logic acc);
        exp_t x;
        logic b;
        b = bad;
`ifndef DECODER3X8_PARITY_EN
        b = 1'b0;
`endif
        @(posedge clk);
        #1;
        en = e;
        valid = v;
        {x2, x1, x0} = c;
`ifdef DECODER3X8_PARITY_EN
        p = (^c) ^ b;
`endif
        x.r = e && rem <= 1;
        x.y = (line >= 0) ? 8'(1) << line : 8'd0;
        x.d = (rem == 1);
        x.e = err_pend;
        q.push_back(x);
        acc = v && x.r;
        err_pend = acc && b;
        if (!e) begin
            line = -1;
            rem = 0;
        end else if (acc && !b) begin
            line = int'(c);
            rem = H;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) line = -1;
        end
    endtask

    task automatic step(input logic e, input logic v, input logic [2:0] c);
        logic a;
        cycle(e, v, c, 1'b0, a);
    endtask

    exp_t mx;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mx = q.pop_front();
            tests++;
            if (ready !== mx.r || yv() !== mx.y || done !== mx.d
`ifdef DECODER3X8_PARITY_EN
                || err !== mx.e
`endif
               ) begin
                fails++;
                $display("FAIL cycle@%0t: ready=%b y=%b done=%b, required ready=%b y=%b done=%b err=%b",
                         $time, ready, yv(), done, mx.r, mx.y, mx.d, mx.e);
            end
        end
    end

    initial begin
        logic acc;
        int   g;
        rst = 1'b1;
        en = 1'b0;
        valid = 1'b0;
        {x2, x1, x0} = 3'd0;
`ifdef DECODER3X8_PARITY_EN
        p = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_y", yv(), 8'd0);
        check("reset_done", {7'd0, done}, 8'd0);
        check("reset_ready_en0", {7'd0, ready}, 8'd0);
        en = 1'b1;
        #1;
        check("reset_ready_en1", {7'd0, ready}, 8'd1);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Single code 5, one-cycle valid.
        step(1, 1, 3'd5);
        repeat (6) step(1, 0, 3'd5);

        // Codes 0..7 with valid held until each is accepted.
        for (int i = 0; i < 8; i++) begin
            g = 0;
            do begin
                cycle(1, 1, 3'(i), 1'b0, acc);
                g++;
            end while (!acc && g <= 2 * H);
            if (!acc) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout code %0d: not accepted, required accepted", i);
            end
        end
        repeat (5) step(1, 0, 3'd0);

        // Abort with en low mid-hold of code 3.
        step(1, 1, 3'd3);
        step(1, 0, 3'd3);
        step(1, 0, 3'd3);
        step(0, 1, 3'd3);
        step(0, 1, 3'd3);
        repeat (2) step(1, 0, 3'd0);

        // Valid code 6 mid-hold of code 2: dropped before cnt==0, then held through cnt==0.
        step(1, 1, 3'd2);
        step(1, 1, 3'd6);
        step(1, 1, 3'd6);
        repeat (6) step(1, 0, 3'd0);
        step(1, 1, 3'd2);
        repeat (H) step(1, 1, 3'd6);
        repeat (6) step(1, 0, 3'd0);

        // Asynchronous reset mid-hold of code 7.
        step(1, 1, 3'd7);
        step(1, 0, 3'd7);
        step(1, 0, 3'd7);
        @(negedge clk);
        #1;
        check("pre_rst_y7", yv(), 8'h80);
        rst = 1'b1;
        #1;
        check("async_rst_y", yv(), 8'd0);
        check("async_rst_done", {7'd0, done}, 8'd0);
        line = -1;
        rem = 0;
        err_pend = 1'b0;
        @(posedge clk);
        #1;
        check("rst_hold_y", yv(), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step(1, 0, 3'd0);

`ifdef DECODER3X8_PARITY_EN
        cycle(1, 1, 3'd1, 1'b1, acc);
        repeat (3) step(1, 0, 3'd0);
        cycle(1, 1, 3'd1, 1'b0, acc);
        repeat (6) step(1, 0, 3'd0);
`endif

        // Randomized traffic.
        repeat (400) begin
            cycle($urandom_range(0, 15) != 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 7) == 0, acc);
        end
        repeat (2) step(1, 0, 3'd0);

        g = 0;
        while (q.size() > 0 && g < 10) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/decoder3x8_hold.md
# decoder3x8_hold

Registered 3-to-8 decoder with a valid/ready input handshake and a programmable output hold time. It accepts a 3-bit code (x2 x1 x0, as produced by the team's 8x3 encoder), drives the matching one-hot line y0..y7 for exactly HOLD_CYCLES clocks, then releases it. It sits on the receiving end of the encoder path, reconstructing line activations from encoded events.

## Interface
- HOLD_CYCLES, 4, clocks each decoded line stays asserted; legal range 1..255.
- CW, $clog2(HOLD_CYCLES+1), hold counter width; derived, not overridden.

- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- en  input  1  block enable; low aborts any hold and blocks acceptance.
- valid  input  1  code on x2..x0 is valid this cycle.
- x0, x1, x2  input  1 each  code bits, x0 = LSB.
- p  input  1  even-parity bit over x0..x2 (present only with DECODER3X8_PARITY_EN).
- ready  output  1  block accepts a code this cycle.
- y0..y7  output  1 each  one-hot decoded lines, registered.
- done  output  1  one-cycle pulse on the last asserted cycle of a hold.
- err  output  1  one-cycle parity-error pulse (present only with DECODER3X8_PARITY_EN).

## Operation
- Accept = en & valid & ready, sampled on the rising clk edge.
- FSM states: IDLE, HOLD.
- IDLE: ready = en; y0..y7 = 0. On accept: latch code, load cnt = HOLD_CYCLES-1, go to HOLD.
- HOLD: y[code] = 1, all other y = 0; cnt decrements by 1 per cycle. ready = en & (cnt == 0); done = (cnt == 0).
- HOLD with cnt == 0: accept -> reload code and cnt, stay in HOLD (back-to-back, no gap); otherwise -> IDLE.
- en low in any state: next edge -> IDLE, y cleared, cnt = 0; no done pulse for the aborted hold.
- valid without ready: ignored, not queued.
- Code change on x while in HOLD without accept: no effect on y.
- At most one y line asserted in any cycle.

## Timing
- Reset (async assert, sync release on next edge): state IDLE, y0..y7 = 0, done = 0, err = 0, cnt = 0, latched code = 0. ready = en combinationally from IDLE.
- Latency: accept at edge N -> y[code] high from edge N through edge N+HOLD_CYCLES (exactly HOLD_CYCLES cycles).
- done high in the final high cycle of y.
- ready is combinational from state, cnt, en; y, done, err are registered.
- HOLD_CYCLES = 1: every HOLD cycle has cnt == 0; a new code is accepted every cycle under continuous valid.
- rst asserted mid-HOLD: y clears immediately (asynchronous), no done.

## Configuration
- DECODER3X8_PARITY_EN defined: ports p and err exist. At accept, if x0^x1^x2^p == 1 the code is dropped: no state change (IDLE stays IDLE; a HOLD at cnt == 0 proceeds to IDLE), err pulses high the following cycle. ready is unaffected.
- Not defined: p and err are absent; every accepted code is decoded.

## Test plan
- Reset then en=1, valid=1, code=5 for one cycle, HOLD_CYCLES=4 -> y5 high exactly 4 cycles starting the next edge, done high in the 4th, all other y low throughout.
- Codes 0..7 in sequence held valid continuously -> y0..y7 each high 4 cycles with no gap, each accepted on the preceding done cycle.
- Accept code 3, drop en after 2 cycles -> y3 clears on the next edge, no done, ready low while en is low.
- valid=1 with code 6 while mid-hold of code 2 (cnt != 0) -> y2 unaffected, code 6 not decoded unless still valid at cnt == 0.
- Assert rst mid-hold of code 7 -> y7 drops without a clock edge; after release, y all 0, ready = en.
- With DECODER3X8_PARITY_EN: code 1, p=0 (bad) -> err pulses one cycle, all y stay 0; code 1, p=1 -> y1 held 4 cycles, err stays 0.
